// File: rtl/vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vga_mem_arbiter
// Shares one synchronous RAM (1-cycle read latency) between the VGA text-mode
// read master and the CPU data bus. A VGA strobe always owns the RAM in its
// cycle. CPU accesses are placed in the idle cycles that the VGA fetch pattern
// leaves, and i_vga_access gives one cycle of warning before each VGA strobe.
//
// Ports
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_vga_addr/cs/access        VGA read request plus next-cycle warning
//   o_vga_dat                   RAM read data passed straight to VGA
//   i_cpu_addr/dat/cs/we        CPU request, held until o_cpu_ack
//   o_cpu_dat, o_cpu_ack        CPU read data and one-cycle completion pulse
//   o_ram_addr/dat/cs/we        RAM command
//   i_ram_dat                   RAM read data, one cycle after o_ram_cs
//
// Optional build macro MEM_ARB_STATS_EN adds:
//   o_stall_cnt[15:0]           saturating count of denied CPU request cycles
//   o_collision                 sticky flag, VGA strobe seen during a CPU cycle
// ---------------------------------------------------------------------------
module vga_mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_vga_addr,
    input  logic              i_vga_cs,
    input  logic              i_vga_access,
    output logic [DATA_W-1:0] o_vga_dat,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_dat,
    input  logic              i_cpu_cs,
    input  logic              i_cpu_we,
    output logic [DATA_W-1:0] o_cpu_dat,
    output logic              o_cpu_ack,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_dat,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    input  logic [DATA_W-1:0] i_ram_dat
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       o_stall_cnt,
    output logic              o_collision
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_CYC = 2'd1;
    localparam logic [1:0] CPU_ACK = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              latch_req;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic [DATA_W-1:0] cpu_dat_q;
    logic              cpu_we_q;
    logic [DATA_W-1:0] cpu_rdat_q;
    logic              rd_done;

    // Next-state logic; a VGA strobe inside CPU_CYC drops the CPU cycle
    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        case (state)
            IDLE: begin
                if (i_cpu_cs && !i_vga_access) begin
                    state_nxt = CPU_CYC;
                    latch_req = 1'b1;
                end
            end
            CPU_CYC: state_nxt = i_vga_cs ? IDLE : CPU_ACK;
            CPU_ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Captured CPU request, held through CPU_CYC and CPU_ACK
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cpu_addr_q <= '0;
            cpu_dat_q  <= '0;
            cpu_we_q   <= 1'b0;
        end else if (latch_req) begin
            cpu_addr_q <= i_cpu_addr;
            cpu_dat_q  <= i_cpu_dat;
            cpu_we_q   <= i_cpu_we;
        end
    end

    // Ack is high exactly in CPU_ACK, i.e. only after an uncontested RAM cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cpu_ack <= 1'b0;
        end else begin
            o_cpu_ack <= (state == CPU_CYC) && !i_vga_cs;
        end
    end

    // RAM data arrives in the ack cycle: forward it then, hold it afterwards
    assign rd_done   = o_cpu_ack && !cpu_we_q;
    assign o_cpu_dat = rd_done ? i_ram_dat : cpu_rdat_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cpu_rdat_q <= '0;
        end else if (rd_done) begin
            cpu_rdat_q <= i_ram_dat;
        end
    end

    // RAM command mux; the VGA strobe overrides everything and never writes
    always_comb begin
        o_ram_addr = cpu_addr_q;
        o_ram_dat  = cpu_dat_q;
        o_ram_cs   = 1'b0;
        o_ram_we   = 1'b0;
        if (i_vga_cs) begin
            o_ram_addr = i_vga_addr;
            o_ram_cs   = 1'b1;
        end else if (state == CPU_CYC) begin
            o_ram_cs   = 1'b1;
            o_ram_we   = cpu_we_q;
        end
    end

    assign o_vga_dat = i_ram_dat;

`ifdef MEM_ARB_STATS_EN
    // Denied-request counter and sticky collision flag
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stall_cnt <= 16'd0;
            o_collision <= 1'b0;
        end else begin
            if ((state == IDLE) && i_cpu_cs && i_vga_access && (o_stall_cnt != 16'hFFFF)) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
            if ((state == CPU_CYC) && i_vga_cs) begin
                o_collision <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_mem_arbiter
// Directed scenarios followed by randomized VGA/CPU traffic. A transaction
// level reference (scheduled RAM slot, ack slot, shadow memory) predicts every
// RAM command, ack and data word cycle by cycle.
// ---------------------------------------------------------------------------
module tb_vga_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] vga_addr;
    logic          vga_cs;
    logic          vga_access;
    logic [DW-1:0] vga_dat;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dat;
    logic          cpu_cs;
    logic          cpu_we;
    logic [DW-1:0] cpu_rdat;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat;
    logic          ram_cs;
    logic          ram_we;
    logic [DW-1:0] ram_rdat;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic          collision;
`endif

    always #5 clk = ~clk;

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_vga_addr   (vga_addr),
        .i_vga_cs     (vga_cs),
        .i_vga_access (vga_access),
        .o_vga_dat    (vga_dat),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_dat    (cpu_dat),
        .i_cpu_cs     (cpu_cs),
        .i_cpu_we     (cpu_we),
        .o_cpu_dat    (cpu_rdat),
        .o_cpu_ack    (cpu_ack),
        .o_ram_addr   (ram_addr),
        .o_ram_dat    (ram_wdat),
        .o_ram_cs     (ram_cs),
        .o_ram_we     (ram_we),
        .i_ram_dat    (ram_rdat)
`ifdef MEM_ARB_STATS_EN
        ,
        .o_stall_cnt  (stall_cnt),
        .o_collision  (collision)
`endif
    );

    // Background RAM contents for never-written words
    function automatic logic [DW-1:0] bg(input logic [AW-1:0] a);
        return DW'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Synchronous RAM with one-cycle read latency
    logic [DW-1:0] mem [int];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[int'(ram_addr)] = ram_wdat;
            else        ram_q <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : bg(ram_addr);
        end
    end
    assign ram_rdat = ram_q;

    // Reference model
    logic [DW-1:0] ref_mem [int];
    int            cyc;
    int            op_cyc;
    int            ack_cyc;
    int            next_free;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_dat;
    logic          op_we;
    logic [DW-1:0] last_rd;
    int            m_stall;
    logic          m_coll;
    logic          prev_vga_cs;
    logic [AW-1:0] prev_vga_addr;
    logic          exp_ack;

    // Driver bookkeeping
    logic          auto_cpu;
    logic          req_pending;
    int            req_start;
    int            lat_from;
    logic          lat_en;

    int n_checks;
    int n_pass;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : bg(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        op_cyc      = -1;
        ack_cyc     = -1;
        next_free   = cyc;
        last_rd     = '0;
        m_stall     = 0;
        m_coll      = 1'b0;
        prev_vga_cs = 1'b0;
    endtask

    // Check the current cycle against the model, then advance one clock
    task automatic step();
        #2;
        check("ram_cs", 32'(ram_cs), 32'(vga_cs || (cyc == op_cyc)));
        if (vga_cs) begin
            check("ram_addr_vga", 32'(ram_addr), 32'(vga_addr));
            check("ram_we_vga", 32'(ram_we), 32'd0);
        end else if (cyc == op_cyc) begin
            check("ram_addr_cpu", 32'(ram_addr), 32'(op_addr));
            check("ram_we_cpu", 32'(ram_we), 32'(op_we));
            if (op_we) check("ram_wdat", 32'(ram_wdat), 32'(op_dat));
        end else begin
            check("ram_we_idle", 32'(ram_we), 32'd0);
        end
        exp_ack = (cyc == ack_cyc);
        check("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
        if (exp_ack && !op_we) last_rd = ref_rd(op_addr);
        check("cpu_dat", 32'(cpu_rdat), 32'(last_rd));
        if (prev_vga_cs) check("vga_dat", 32'(vga_dat), 32'(ref_rd(prev_vga_addr)));
        if (exp_ack && lat_en && (req_start >= lat_from))
            check("lat_le4", 32'((cyc - req_start) <= 4), 32'd1);
`ifdef MEM_ARB_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("collision", 32'(collision), 32'(m_coll));
`endif
        // advance the model over this clock edge
        if (cyc == op_cyc) begin
            if (vga_cs) begin
                m_coll    = 1'b1;
                next_free = cyc + 1;
            end else begin
                ack_cyc   = cyc + 1;
                next_free = cyc + 2;
                if (op_we) ref_mem[int'(op_addr)] = op_dat;
            end
        end else if (cyc >= next_free && cpu_cs) begin
            if (vga_access) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                op_cyc    = cyc + 1;
                op_addr   = cpu_addr;
                op_dat    = cpu_dat;
                op_we     = cpu_we;
                next_free = cyc + 1000;
            end
        end
        if (exp_ack) req_pending = 1'b0;
        prev_vga_cs   = vga_cs;
        prev_vga_addr = vga_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Random stimulus: 0 VGA idle, 1 fixed fetch pattern, 2 random legal, 3 with collisions
    task automatic drive(input int mode);
        int ph;
        if (auto_cpu && !req_pending && ($urandom_range(0, 3) != 0)) begin
            cpu_addr    = AW'($urandom_range(0, 31));
            cpu_dat     = DW'($urandom);
            cpu_we      = 1'($urandom_range(0, 1));
            req_pending = 1'b1;
            req_start   = cyc;
        end
        cpu_cs = req_pending;
        case (mode)
            1: begin
                ph         = (cyc - lat_from) % 8;
                vga_access = (ph == 0) || (ph == 2);
                vga_cs     = (ph == 1) || (ph == 3);
            end
            2, 3: begin
                vga_cs     = vga_access;
                vga_access = ($urandom_range(0, 2) == 0);
                if (mode == 3 && cyc == op_cyc && $urandom_range(0, 1) == 1) vga_cs = 1'b1;
            end
            default: begin
                vga_access = 1'b0;
                vga_cs     = 1'b0;
            end
        endcase
        vga_addr = AW'($urandom_range(0, 31));
    endtask

    task automatic cpu_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_cs    = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_dat   = d;
        req_start = cyc;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        auto_cpu = 1'b0; req_pending = 1'b0; lat_en = 1'b0; lat_from = 0; req_start = 0;
        rst_n = 1'b0; vga_addr = '0; vga_cs = 1'b0; vga_access = 1'b0;
        cpu_addr = '0; cpu_dat = '0; cpu_cs = 1'b0; cpu_we = 1'b0;
        op_addr = '0; op_dat = '0; op_we = 1'b0; prev_vga_addr = '0; exp_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_dat", 32'(cpu_rdat), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // 1: unstalled write
        cpu_req(1'b1, 16'h1005, 16'h1234);
        step();
        check("t1_cs", 32'(ram_cs), 32'd1);
        check("t1_we", 32'(ram_we), 32'd1);
        check("t1_addr", 32'(ram_addr), 32'h1005);
        check("t1_dat", 32'(ram_wdat), 32'h1234);
        step();
        check("t1_ack", 32'(cpu_ack), 32'd1);
        cpu_cs = 1'b0;
        step();

        // 2: store 0xBEEF at 0x0042 then read it back
        cpu_req(1'b1, 16'h0042, 16'hBEEF);
        repeat (2) step();
        cpu_cs = 1'b0;
        step();
        cpu_req(1'b0, 16'h0042, 16'h0000);
        repeat (2) step();
        check("t2_ack", 32'(cpu_ack), 32'd1);
        check("t2_dat", 32'(cpu_rdat), 32'hBEEF);
        cpu_cs = 1'b0;
        step();

        // 3: request stalled by a VGA access warning
        cpu_req(1'b0, 16'h1005, 16'h0000);
        vga_access = 1'b1;
        step();
        vga_access = 1'b0; vga_cs = 1'b1; vga_addr = 16'h1000;
        #1;
        check("t3_vga_addr", 32'(ram_addr), 32'h1000);
        step();
        vga_cs = 1'b0;
        #1;
        check("t3_cpu_cyc", 32'(ram_cs), 32'd1);
        check("t3_cpu_addr", 32'(ram_addr), 32'h1005);
        step();
        check("t3_ack", 32'(cpu_ack), 32'd1);
        check("t3_dat", 32'(cpu_rdat), 32'h1234);
        cpu_cs = 1'b0;
        step();

        // 5: VGA strobe forced into the CPU write cycle
        cpu_req(1'b1, 16'h0007, 16'hC0DE);
        step();
        vga_cs = 1'b1; vga_addr = 16'h0007;
        step();
        vga_cs = 1'b0;
        check("t5_no_ack", 32'(cpu_ack), 32'd0);
        repeat (2) step();
        check("t5_retry_ack", 32'(cpu_ack), 32'd1);
        cpu_cs = 1'b0;
        step();
        cpu_req(1'b0, 16'h0007, 16'h0000);
        repeat (2) step();
        check("t5_readback", 32'(cpu_rdat), 32'hC0DE);
        cpu_cs = 1'b0;
        step();

        // 6: reset during CPU_CYC, request reissued afterwards
        cpu_req(1'b1, 16'h0009, 16'hA5A5);
        step();
        rst_n = 1'b0;
        #1;
        check("t6_ram_cs", 32'(ram_cs), 32'd0);
        check("t6_ack", 32'(cpu_ack), 32'd0);
        @(posedge clk);
        #1;
        check("t6_hold_ack", 32'(cpu_ack), 32'd0);
        rst_n = 1'b1;
        cyc++;
        model_reset();
        step();
        step();
        check("t6_reissue_ack", 32'(cpu_ack), 32'd1);
        cpu_cs = 1'b0;
        step();

        // randomized traffic
        auto_cpu = 1'b1;
        lat_from = cyc; lat_en = 1'b1;
        repeat (400) begin drive(1); step(); end
        lat_en = 1'b0;
        repeat (400) begin drive(2); step(); end
        repeat (400) begin drive(3); step(); end
        repeat (200) begin drive(0); step(); end
        auto_cpu = 1'b0;
        for (int i = 0; i < 20 && req_pending; i++) begin drive(0); step(); end
        check("drain", 32'(req_pending), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
